mem_stream_ctrl: RTL and testbench

Stream-side controller for the single-port 2000 x 25-bit buffer memory. It accepts a valid/ready input stream and writes words to sequential memory addresses. On command it replays the stored words as a valid/ready output stream. It drives the memory port (we/addr/din), absorbs the memory's one-cycle registered read latency, and supports output backpressure at full throughput.

---
 rtl/mem_stream_if.sv | 31 +++
 rtl/mem_stream_ctrl.sv | 148 ++++++++++++++
 tb/tb_mem_stream_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stream_if.sv
// Handshake and memory-port bundle between mem_stream_ctrl (master) and its
// environment (slave: stream source/sink plus the buffer memory).
interface mem_stream_if #(
  parameter int DATA_W = 25,
  parameter int ADDR_W = 11
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport master (
    input  in_valid, in_data, in_last, out_ready, mem_dout,
    output in_ready, out_valid, out_data, out_last, mem_we, mem_addr, mem_din
  );

  modport slave (
    output in_valid, in_data, in_last, out_ready, mem_dout,
    input  in_ready, out_valid, out_data, out_last, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/mem_stream_ctrl.sv
// Stream controller for a single-port buffer memory: fills it from an input
// stream, then replays the stored block through a 2-entry output FIFO.
module mem_stream_ctrl #(
  parameter int DATA_W = 25,
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_start,
  input  logic          clear,
  output logic [ADDR_W:0] word_count,
  output logic          busy,
  mem_stream_if.master  bus
);

  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_FILL,
    S_LOADED,
    S_READ
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   rd_ptr;

  logic              rd_vld_p1;
  logic              rd_last_p1;

  logic [DATA_W-1:0] fifo_data [2];
  logic [1:0]        fifo_last;
  logic              fifo_rd;
  logic              fifo_wr;
  logic [1:0]        occ;

  logic              in_fill;
  logic              in_read;
  logic              wr_fire;
  logic              wr_last;
  logic              pop;
  logic [2:0]        level;
  logic              issue;
  logic              start_read;

  assign in_fill    = (state == S_FILL);
  assign in_read    = (state == S_READ);
  assign wr_fire    = in_fill & bus.in_valid;
  assign wr_last    = bus.in_last | (wr_ptr == LAST_ADDR);
  assign pop        = bus.out_valid & bus.out_ready;
  assign start_read = (state == S_LOADED) & rd_start;

  // Buffer level after this edge if nothing new is issued; a new read may
  // only be launched when its word is guaranteed a free FIFO slot.
  assign level = 3'(occ) + 3'(rd_vld_p1) - 3'(pop);
  assign issue = in_read & (rd_ptr < word_count) & (level < 3'd2);

  // Write path is combinational so the word lands on the handshake edge;
  // the reset gate keeps the memory port quiet while rst_n is low.
  assign bus.in_ready = in_fill;
  assign bus.mem_we   = wr_fire & rst_n;
  assign bus.mem_din  = bus.mem_we ? bus.in_data : '0;
  assign bus.mem_addr = in_read ? rd_ptr[ADDR_W-1:0] :
                        in_fill ? wr_ptr : '0;

  assign bus.out_valid = (occ != 2'd0);
  assign bus.out_data  = fifo_data[fifo_rd];
  assign bus.out_last  = bus.out_valid & fifo_last[fifo_rd];
  assign busy          = in_read;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FILL;
      wr_ptr     <= '0;
      word_count <= '0;
      rd_ptr     <= '0;
    end else begin
      case (state)
        S_FILL: begin
          if (wr_fire) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (word_count != DEPTH_CNT) begin
              word_count <= word_count + 1'b1;
            end
            if (wr_last) begin
              state <= S_LOADED;
            end
          end
        end
        S_LOADED: begin
          if (rd_start) begin
            state  <= S_READ;
            rd_ptr <= '0;
          end else if (clear) begin
            state      <= S_FILL;
            wr_ptr     <= '0;
            word_count <= '0;
          end
        end
        S_READ: begin
          if (issue) begin
            rd_ptr <= rd_ptr + 1'b1;
          end
          if (pop && fifo_last[fifo_rd]) begin
            state <= S_LOADED;
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

  // p1: read issued last edge, memory word is now on mem_dout -> FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_p1    <= 1'b0;
      rd_last_p1   <= 1'b0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last    <= '0;
      fifo_rd      <= 1'b0;
      fifo_wr      <= 1'b0;
      occ          <= '0;
    end else if (start_read) begin
      rd_vld_p1  <= 1'b0;
      rd_last_p1 <= 1'b0;
      fifo_last  <= '0;
      fifo_rd    <= 1'b0;
      fifo_wr    <= 1'b0;
      occ        <= '0;
    end else if (in_read) begin
      rd_vld_p1  <= issue;
      rd_last_p1 <= (rd_ptr == word_count - 1'b1);
      if (rd_vld_p1) begin
        fifo_data[fifo_wr] <= bus.mem_dout;
        fifo_last[fifo_wr] <= rd_last_p1;
        fifo_wr            <= ~fifo_wr;
      end
      if (pop) begin
        fifo_rd <= ~fifo_rd;
      end
      occ <= occ + 2'(rd_vld_p1) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_mem_stream_ctrl.sv
// Bench for mem_stream_ctrl: behavioural buffer memory, scoreboard queue of
// expected replay words, and one task per scenario.
module tb_mem_stream_ctrl;

  localparam int DATA_W = 25;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 2000;

  logic              clk;
  logic              rst_n;
  logic              rd_start;
  logic              clear;
  logic [ADDR_W:0]   word_count;
  logic              busy;

  mem_stream_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_stream_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_start   (rd_start),
    .clear      (clear),
    .word_count (word_count),
    .busy       (busy),
    .bus        (bus)
  );

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  logic [DATA_W:0]   exp_q [$];
  logic [DATA_W:0]   e;
  logic [DATA_W-1:0] blk [0:7];
  logic              hold_vld = 1'b0;
  logic [DATA_W-1:0] hold_data;
  logic              hold_last;

  logic [DATA_W-1:0] mem [0:2047];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory with a registered read port.
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
    else            bus.mem_dout      <= mem[bus.mem_addr];
  end

  // Scoreboard and stall-stability monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) begin
        checks++;
        if (!bus.out_valid || bus.out_data !== hold_data || bus.out_last !== hold_last) begin
          errors++;
          $display("FAIL stall_stable: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   bus.out_valid, bus.out_data, bus.out_last, hold_data, hold_last);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        pops++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got d=%h l=%b want no output", bus.out_data, bus.out_last);
        end else begin
          e = exp_q.pop_front();
          if ({bus.out_last, bus.out_data} !== e) begin
            errors++;
            $display("FAIL out_word: got l=%b d=%h want l=%b d=%h",
                     bus.out_last, bus.out_data, e[DATA_W], e[DATA_W-1:0]);
          end
        end
      end
      hold_vld  = bus.out_valid && !bus.out_ready;
      hold_data = bus.out_data;
      hold_last = bus.out_last;
    end
  end

  task automatic write_word(input logic [DATA_W-1:0] d, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic pulse(input logic rs, input logic cl);
    rd_start = rs;
    clear    = cl;
    @(posedge clk); #1;
    rd_start = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic write_blk(input int n);
    for (int i = 0; i < n; i++) write_word(blk[i], i == n - 1);
  endtask

  task automatic push_blk(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, blk[i]});
  endtask

  task automatic wait_idle(input int bound);
    for (int n = 0; n < bound && (exp_q.size() != 0 || busy); n++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rd_start = 1'b0; clear = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 25'h1ABCDEF; bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_last, busy, bus.mem_we} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy=%b ov=%b ol=%b busy=%b we=%b want 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_last, busy, bus.mem_we);
    end
    checks++;
    if (bus.out_data !== '0 || word_count !== '0 || bus.mem_addr !== '0 || bus.mem_din !== '0) begin
      errors++;
      $display("FAIL reset_data: got od=%h wc=%0d ma=%0d md=%h want all 0",
               bus.out_data, word_count, bus.mem_addr, bus.mem_din);
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_replay;
    logic exp_v;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DATA_W'(i + 1);
      bus.in_last  = (i == 4);
      #1;
      checks++;
      if (bus.mem_we !== 1'b1 || bus.mem_addr !== ADDR_W'(i) || bus.mem_din !== DATA_W'(i + 1)) begin
        errors++;
        $display("FAIL fill_port: got we=%b a=%0d d=%h want we=1 a=%0d d=%h",
                 bus.mem_we, bus.mem_addr, bus.mem_din, i, i + 1);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
    end
    checks++;
    if (word_count !== 12'd5 || bus.in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fill_loaded: got wc=%0d rdy=%b busy=%b want 5 0 0", word_count, bus.in_ready, busy);
    end
    for (int i = 0; i < 5; i++) exp_q.push_back({i == 4, DATA_W'(i + 1)});
    pulse(1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_v = (k >= 2 && k <= 6);
      checks++;
      if (bus.out_valid !== exp_v || busy !== (k <= 6)) begin
        errors++;
        $display("FAIL replay_timing k=%0d: got v=%b busy=%b want v=%b busy=%b",
                 k, bus.out_valid, busy, exp_v, k <= 6);
      end
      if (exp_v) begin
        checks++;
        if (bus.out_data !== DATA_W'(k - 1) || bus.out_last !== (k == 6)) begin
          errors++;
          $display("FAIL replay_data k=%0d: got d=%h l=%b want d=%h l=%b",
                   k, bus.out_data, bus.out_last, k - 1, k == 6);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_commands;
    pulse(1'b0, 1'b1);
    checks++;
    if (word_count !== '0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_loaded: got wc=%0d rdy=%b want 0 1", word_count, bus.in_ready);
    end
    pulse(1'b1, 1'b0);
    checks++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_in_fill: got busy=%b rdy=%b want 0 1", busy, bus.in_ready);
    end
    for (int i = 0; i < 3; i++) blk[i] = DATA_W'(32'h0AA0 + i);
    write_blk(3);
    push_blk(3);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    wait_idle(50);
    checks++;
    if (exp_q.size() != 0 || word_count !== 12'd3 || bus.in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_in_read: got left=%0d wc=%0d rdy=%b busy=%b want 0 3 0 0",
               exp_q.size(), word_count, bus.in_ready, busy);
    end
    push_blk(3);
    pulse(1'b1, 1'b1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL start_and_clear: got busy=%b want 1", busy);
    end
    wait_idle(50);
    checks++;
    if (exp_q.size() != 0 || word_count !== 12'd3) begin
      errors++;
      $display("FAIL start_and_clear_done: got left=%0d wc=%0d want 0 3", exp_q.size(), word_count);
    end
  endtask

  task automatic test_backpressure;
    pulse(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) blk[i] = DATA_W'($urandom);
    write_blk(8);
    push_blk(8);
    pulse(1'b1, 1'b0);
    for (int c = 0; c < 300 && (exp_q.size() != 0 || busy); c++) begin
      bus.out_ready = (c >= 4 && c < 14) ? 1'b0 : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_drain: got left=%0d busy=%b want 0 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_back_to_back;
    push_blk(8);
    pulse(1'b1, 1'b0);
    wait_idle(50);
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0 || word_count !== 12'd8) begin
      errors++;
      $display("FAIL replay_twice: got left=%0d busy=%b wc=%0d want 0 0 8", exp_q.size(), busy, word_count);
    end
  endtask

  task automatic test_full;
    pulse(1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) begin
        checks++;
        if (bus.in_ready !== 1'b1) begin
          errors++;
          $display("FAIL full_early: got rdy=%b want 1 before word %0d", bus.in_ready, i);
        end
      end
      write_word(DATA_W'(i), 1'b0);
    end
    checks++;
    if (word_count !== 12'd2000 || bus.in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_loaded: got wc=%0d rdy=%b busy=%b want 2000 0 0", word_count, bus.in_ready, busy);
    end
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({i == DEPTH - 1, DATA_W'(i)});
    pulse(1'b1, 1'b0);
    wait_idle(2200);
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_replay: got left=%0d busy=%b want 0 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_reset_mid_read;
    int start;
    pulse(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) blk[i] = DATA_W'(32'h100 + i);
    write_blk(6);
    push_blk(6);
    start = pops;
    pulse(1'b1, 1'b0);
    for (int n = 0; n < 50 && pops - start < 3; n++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (pops - start !== 3) begin
      errors++;
      $display("FAIL mid_read_progress: got %0d words want 3", pops - start);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || word_count !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_read_reset: got ov=%b rdy=%b wc=%0d busy=%b want 0 1 0 0",
               bus.out_valid, bus.in_ready, word_count, busy);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_valid: got %b want 0", bus.out_valid);
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 25'h55;
    #1;
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== '0) begin
      errors++;
      $display("FAIL post_reset_addr: got we=%b a=%0d want 1 0", bus.mem_we, bus.mem_addr);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (word_count !== 12'd1 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_count: got wc=%0d rdy=%b want 1 1", word_count, bus.in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_fill_replay();
    test_commands();
    test_backpressure();
    test_back_to_back();
    test_full();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish want finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule
